mips_mc_control: RTL and testbench

Multicycle MIPS control unit. A Moore FSM that sequences the shared datapath one instruction at a time. It drives the write enables for PC, IR, memory and register file, and the select lines of the datapath muxes: the 2:1 IorD/ALUSrcA/RegDst/MemtoReg muxes and the 4:1 ALUSrcB/PCSource muxes. It also handles a memory-ready handshake and keeps a retired-instruction counter. It sits between the IR opcode field and the datapath.

---
 rtl/mips_mc_control.sv | 167 ++++++++++++++++
 tb/tb_mips_mc_control.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath, with a
// memory-ready stall handshake and a retired-instruction counter.
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       OP,
  input  logic             MEM_RDY,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             ILLEGAL,
  output logic [3:0]       STATE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state;
  state_t next;
  logic   retire;

  always_comb begin
    next   = IDLE;
    retire = 1'b0;
    case (state)
      IDLE:   next = FETCH;
      FETCH:  next = MEM_RDY ? DECODE : FETCH;
      DECODE: begin
        case (OP)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXEC;
          OP_BEQ:       next = BEQ;
          OP_J:         next = JUMP;
          OP_ADDI:      next = ADDIEX;
          default:      next = FETCH;
        endcase
      end
      MEMADR: next = (OP == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  next = MEM_RDY ? MEMWB : MEMRD;
      MEMWB:  begin next = FETCH; retire = 1'b1; end
      MEMWR:  begin
        next   = MEM_RDY ? FETCH : MEMWR;
        retire = MEM_RDY;
      end
      EXEC:   next = RWB;
      RWB:    begin next = FETCH; retire = 1'b1; end
      BEQ:    begin next = FETCH; retire = 1'b1; end
      JUMP:   begin next = FETCH; retire = 1'b1; end
      ADDIEX: next = ADDIWB;
      ADDIWB: begin next = FETCH; retire = 1'b1; end
      default: next = IDLE;
    endcase
  end

  // Reset wins over a retirement landing on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      INSTR_CNT <= '0;
    end else begin
      state <= next;
      if (retire) INSTR_CNT <= INSTR_CNT + CNT_W'(1);
    end
  end

  assign STATE = state;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    ILLEGAL     = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = MEM_RDY;   // only latch IR / bump PC once the fetch really completes
        PCWrite = MEM_RDY;
        ALUSrcB = 2'b01;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        ILLEGAL = !(OP == OP_LW || OP == OP_SW || OP == OP_R ||
                    OP == OP_BEQ || OP == OP_J || OP == OP_ADDI);
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: expectations are queued as each step is
// driven and popped when the DUT outputs are sampled mid-cycle.
module tb_mips_mc_control;

  logic       CLK;
  logic       rst_a;
  logic       rst_b;
  logic [5:0] OP;
  logic       MEM_RDY;

  logic        pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a, ill_a;
  logic [1:0]  asb_a, aop_a, pcs_a;
  logic [3:0]  st_a;
  logic [31:0] cnt_a;

  logic        pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b, ill_b;
  logic [1:0]  asb_b, aop_b, pcs_b;
  logic [3:0]  st_b;
  logic [1:0]  cnt_b;

  mips_mc_control #(.CNT_W(32)) dut_a (
    .CLK(CLK), .RST(rst_a), .OP(OP), .MEM_RDY(MEM_RDY),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .IorD(iord_a), .MemRead(mrd_a),
    .MemWrite(mwr_a), .IRWrite(irw_a), .MemtoReg(m2r_a), .RegDst(rdst_a),
    .RegWrite(rw_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a), .ALUOp(aop_a),
    .PCSource(pcs_a), .ILLEGAL(ill_a), .STATE(st_a), .INSTR_CNT(cnt_a)
  );

  mips_mc_control #(.CNT_W(2)) dut_b (
    .CLK(CLK), .RST(rst_b), .OP(OP), .MEM_RDY(MEM_RDY),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .IorD(iord_b), .MemRead(mrd_b),
    .MemWrite(mwr_b), .IRWrite(irw_b), .MemtoReg(m2r_b), .RegDst(rdst_b),
    .RegWrite(rw_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(aop_b),
    .PCSource(pcs_b), .ILLEGAL(ill_b), .STATE(st_b), .INSTR_CNT(cnt_b)
  );

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource,ILLEGAL}
  logic [16:0] ctl_a, ctl_b;
  assign ctl_a = {pcw_a, pcwc_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a, asb_a, aop_a, pcs_a, ill_a};
  assign ctl_b = {pcw_b, pcwc_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b, asb_b, aop_b, pcs_b, ill_b};

  localparam logic [16:0] C_IDLE    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_FETCH   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_FSTALL  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] C_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] C_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] C_BEQ     = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] C_ADDIEX  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, AI = 6'b001000, BAD = 6'b111111;

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive inputs for the current cycle, queue what the DUT must show, sample, advance.
  task automatic step(input bit sel, input string tag, input logic rst, input logic [5:0] op,
                      input logic rdy, input logic [3:0] st, input logic [16:0] ctl,
                      input logic [31:0] cnt);
    exp_t e;
    logic [3:0]  o_st;
    logic [16:0] o_ctl;
    logic [31:0] o_cnt;
    if (sel) rst_b = rst; else rst_a = rst;
    OP      = op;
    MEM_RDY = rdy;
    sb.push_back('{tag, st, ctl, cnt});
    #1;
    e     = sb.pop_front();
    o_st  = sel ? st_b  : st_a;
    o_ctl = sel ? ctl_b : ctl_a;
    o_cnt = sel ? {30'd0, cnt_b} : cnt_a;
    checks++;
    assert (o_st === e.st) else begin
      errors++;
      $error("FAIL %s.state observed=%0d expected=%0d", e.tag, o_st, e.st);
    end
    checks++;
    assert (o_ctl === e.ctl) else begin
      errors++;
      $error("FAIL %s.ctl observed=%b expected=%b", e.tag, o_ctl, e.ctl);
    end
    checks++;
    assert (o_cnt === e.cnt) else begin
      errors++;
      $error("FAIL %s.cnt observed=%0d expected=%0d", e.tag, o_cnt, e.cnt);
    end
    @(negedge CLK);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; OP = RT; MEM_RDY = 1'b1;
    @(negedge CLK);

    step(0, "rst_idle", 0, LW, 1, 4'd0, C_IDLE, 0);
    // lw, no stalls
    step(0, "lw_f",   0, LW, 1, 4'd1, C_FETCH,  0);
    step(0, "lw_d",   0, LW, 1, 4'd2, C_DEC,    0);
    step(0, "lw_ma",  0, LW, 1, 4'd3, C_MEMADR, 0);
    step(0, "lw_mr",  0, LW, 1, 4'd4, C_MEMRD,  0);
    step(0, "lw_wb",  0, LW, 1, 4'd5, C_MEMWB,  0);
    // R-type, beq, j
    step(0, "r_f",    0, RT, 1, 4'd1, C_FETCH,  1);
    step(0, "r_d",    0, RT, 1, 4'd2, C_DEC,    1);
    step(0, "r_ex",   0, RT, 1, 4'd7, C_EXEC,   1);
    step(0, "r_wb",   0, RT, 1, 4'd8, C_RWB,    1);
    step(0, "beq_f",  0, BQ, 1, 4'd1, C_FETCH,  2);
    step(0, "beq_d",  0, BQ, 1, 4'd2, C_DEC,    2);
    step(0, "beq_x",  0, BQ, 1, 4'd9, C_BEQ,    2);
    step(0, "j_f",    0, JP, 1, 4'd1, C_FETCH,  3);
    step(0, "j_d",    0, JP, 1, 4'd2, C_DEC,    3);
    step(0, "j_x",    0, JP, 1, 4'd10, C_JUMP,  3);
    // sw with 3 fetch stalls and 2 write stalls
    step(0, "sw_fs1", 0, SW, 0, 4'd1, C_FSTALL, 4);
    step(0, "sw_fs2", 0, SW, 0, 4'd1, C_FSTALL, 4);
    step(0, "sw_fs3", 0, SW, 0, 4'd1, C_FSTALL, 4);
    step(0, "sw_f",   0, SW, 1, 4'd1, C_FETCH,  4);
    step(0, "sw_d",   0, SW, 0, 4'd2, C_DEC,    4);
    step(0, "sw_ma",  0, SW, 0, 4'd3, C_MEMADR, 4);
    step(0, "sw_ws1", 0, SW, 0, 4'd6, C_MEMWR,  4);
    step(0, "sw_ws2", 0, SW, 0, 4'd6, C_MEMWR,  4);
    step(0, "sw_w",   0, SW, 1, 4'd6, C_MEMWR,  4);
    // illegal opcode
    step(0, "ill_f",  0, BAD, 1, 4'd1, C_FETCH,   5);
    step(0, "ill_d",  0, BAD, 1, 4'd2, C_DEC_ILL, 5);
    // lw interrupted by a 2-cycle reset while in MEMRD
    step(0, "lw2_f",  0, LW, 1, 4'd1, C_FETCH,  5);
    step(0, "lw2_d",  0, LW, 1, 4'd2, C_DEC,    5);
    step(0, "lw2_ma", 0, LW, 1, 4'd3, C_MEMADR, 5);
    step(0, "lw2_mr", 1, LW, 0, 4'd4, C_MEMRD,  5);
    step(0, "rst2_a", 1, LW, 1, 4'd0, C_IDLE,   0);
    step(0, "rst2_b", 0, LW, 1, 4'd0, C_IDLE,   0);
    step(0, "post_f", 0, LW, 1, 4'd1, C_FETCH,  0);
    step(0, "post_d", 0, LW, 1, 4'd2, C_DEC,    0);
    rst_a = 1'b1;

    // narrow counter wraps after four addi retirements
    step(1, "b_idle", 0, AI, 1, 4'd0, C_IDLE, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, "ai_f",  0, AI, 1, 4'd1,  C_FETCH,  32'(i % 4));
      step(1, "ai_d",  0, AI, 1, 4'd2,  C_DEC,    32'(i % 4));
      step(1, "ai_ex", 0, AI, 1, 4'd11, C_ADDIEX, 32'(i % 4));
      step(1, "ai_wb", 0, AI, 1, 4'd12, C_ADDIWB, 32'(i % 4));
    end
    step(1, "ai_end", 0, AI, 1, 4'd1, C_FETCH, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
